bus_fabric: RTL and testbench

- Parametrised successor to the fixed three-target system bus.
- Connects the single CPU bus master to N_SLAVES memory-mapped targets (ROM, stack, IO, future peripherals) through a registered request/response handshake.
- Base/mask address windows are set by parameters; overlapping windows resolve by priority.
- Unmapped accesses and per-transaction timeouts return a bus error instead of hanging the CPU.

---
 rtl/bus_fabric_pkg.sv | 16 +
 rtl/bus_addr_decode.sv | 35 +++
 rtl/bus_fabric.sv | 191 +++++++++++++++++++
 tb/tb_bus_fabric.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the CPU bus fabric and its address decoder.
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_t;

    localparam logic [31:0] BUS_ERR_RDATA = 32'hDEAD_BEEF;

    // Sized for the largest supported fabric (8 targets) so decoders are interchangeable.
    localparam int SLV_IDX_W = $clog2(8);
    typedef logic [SLV_IDX_W-1:0] slave_idx_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Priority base/mask address decoder: lowest matching slave index wins.
module bus_addr_decode
    import bus_fabric_pkg::*;
#(
    parameter int                         N_SLAVES   = 3,
    parameter int                         ADDR_W     = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'hF000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output slave_idx_t        idx,
    output logic [ADDR_W-1:0] offset
);

    logic [ADDR_W-1:0] mask_s;
    logic              match_s;

    // Walk from the highest index down so a lower-index match overrides.
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        offset  = '0;
        mask_s  = '0;
        match_s = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            mask_s  = SLAVE_MASK[i*ADDR_W +: ADDR_W];
            match_s = ((addr & mask_s) == (SLAVE_BASE[i*ADDR_W +: ADDR_W] & mask_s));
            hit     = hit | match_s;
            idx     = match_s ? slave_idx_t'(i) : idx;
            offset  = match_s ? (addr & ~mask_s) : offset;
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Single-master bus fabric: registered request/response to N memory-mapped
// targets, with bus-error responses for unmapped addresses and stalled targets.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                         N_SLAVES   = 3,
    parameter int                         ADDR_W     = 32,
    parameter int                         DATA_W     = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'hF000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
    parameter int                         TIMEOUT    = 255,
    parameter logic [DATA_W-1:0]          ERR_RDATA  = BUS_ERR_RDATA
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       bus_req,
    input  logic                       bus_we,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [DATA_W-1:0]          bus_wdata,
    output logic [DATA_W-1:0]          bus_rdata,
    output logic                       bus_ready,
    output logic                       bus_err,
    output logic [ADDR_W-1:0]          err_addr,
    output logic [N_SLAVES-1:0]        s_sel,
    output logic                       s_we,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [N_SLAVES-1:0]        s_ready
);

    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    bus_state_t          state_q, state_d;
    logic [N_SLAVES-1:0] sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   full_addr_q, full_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    logic                dec_hit_s;
    slave_idx_t          dec_idx_s;
    logic [ADDR_W-1:0]   dec_offset_s;
    logic [N_SLAVES-1:0] dec_onehot_s;
    logic                sel_ready_s;
    logic [DATA_W-1:0]   sel_rdata_s;
    logic                timeout_s;

    bus_addr_decode #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr   (bus_addr),
        .hit    (dec_hit_s),
        .idx    (dec_idx_s),
        .offset (dec_offset_s)
    );

    // Ready and read data only count from the currently selected slave.
    always_comb begin
        dec_onehot_s = '0;
        sel_rdata_s  = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            dec_onehot_s[i] = (dec_idx_s == slave_idx_t'(i));
            sel_rdata_s     = sel_rdata_s | ({DATA_W{sel_q[i]}} & s_rdata[i*DATA_W +: DATA_W]);
        end
        sel_ready_s = |(sel_q & s_ready);
        timeout_s   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            full_addr_q <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            full_addr_q <= full_addr_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            err_addr_q  <= err_addr_d;
        end
    end

    // Next-state logic; a ready on the timeout cycle takes precedence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus_req) begin
                    state_d = dec_hit_s ? ACCESS : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (sel_ready_s || timeout_s) begin
                    state_d = RESP;
                end else begin
                    state_d = ACCESS;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath/output register updates per state.
    always_comb begin
        sel_d       = sel_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        full_addr_d = full_addr_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        err_addr_d  = err_addr_q;
        case (state_q)
            IDLE: begin
                if (bus_req && dec_hit_s) begin
                    sel_d       = dec_onehot_s;
                    we_d        = bus_we;
                    addr_d      = dec_offset_s;
                    wdata_d     = bus_wdata;
                    full_addr_d = bus_addr;
                    cnt_d       = '0;
                end else if (bus_req) begin
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = ERR_RDATA;
                    err_addr_d = bus_addr;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ACCESS: begin
                if (sel_ready_s) begin
                    sel_d   = '0;
                    ready_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : sel_rdata_s;
                end else if (timeout_s) begin
                    sel_d      = '0;
                    ready_d    = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = ERR_RDATA;
                    err_addr_d = full_addr_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    ready_d = 1'b0;
            default: sel_d   = '0;
        endcase
    end

    assign bus_rdata = rdata_q;
    assign bus_ready = ready_q;
    assign bus_err   = err_q;
    assign err_addr  = err_addr_q;
    assign s_sel     = sel_q;
    assign s_we      = we_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: responses are predicted when requests are
// issued and compared as bus_ready strobes arrive.
module tb_bus_fabric;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         bus_req;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [31:0]  bus_rdata;
    logic         bus_ready;
    logic         bus_err;
    logic [31:0]  err_addr;
    logic [2:0]   s_sel;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [95:0]  s_rdata;
    logic [2:0]   s_ready;

    logic [31:0]  o_rdata;
    logic         o_ready;
    logic         o_err;
    logic [31:0]  o_err_addr;
    logic [2:0]   o_sel;
    logic         o_we;
    logic [31:0]  o_addr;
    logic [31:0]  o_wdata;

    int           wait_cfg;
    int           wcnt;
    logic [2:0]   extra_ready;
    logic [2:0]   ovl_sel_c1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;
    exp_t sb_q[$];

    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'hA5A5_0001;
    localparam logic [31:0] D2 = 32'h0BAD_F00D;

    always #5 clk = ~clk;

    assign s_rdata = {D2, D1, D0};
    assign s_ready = ((wcnt >= wait_cfg) ? s_sel : 3'b000) | extra_ready;

    always @(posedge clk) wcnt <= (s_sel == 3'b000) ? 0 : wcnt + 1;

    bus_fabric #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .bus_err(bus_err), .err_addr(err_addr),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready)
    );

    // Second fabric whose slave 1 window duplicates slave 0.
    bus_fabric #(
        .TIMEOUT    (4),
        .SLAVE_BASE ({32'hF000_0000, 32'h0000_0000, 32'h0000_0000})
    ) u_ovl (
        .clk(clk), .reset_n(reset_n), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(o_rdata),
        .bus_ready(o_ready), .bus_err(o_err), .err_addr(o_err_addr),
        .s_sel(o_sel), .s_we(o_we), .s_addr(o_addr), .s_wdata(o_wdata),
        .s_rdata(s_rdata), .s_ready(o_sel)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every strobe must match the oldest prediction.
    always @(negedge clk) begin
        if (reset_n && bus_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_resp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("resp_rdata", bus_rdata, e.rdata);
                check_val("resp_err", bus_err, e.err);
                check_val("resp_err_addr", err_addr, e.eaddr);
            end
        end
    end

    task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input int wt, input logic [2:0] exp_sel,
                       input logic [31:0] exp_saddr, input int exp_lat,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [31:0] exp_eaddr);
        int   lat;
        int   nsel;
        int   unstable;
        logic got;
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.eaddr = exp_eaddr;
        sb_q.push_back(e);
        wait_cfg  = wt;
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        lat = 0; nsel = 0; unstable = 0; got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                ovl_sel_c1 = o_sel;
                check_val({tag, "_sel"}, s_sel, exp_sel);
                if (exp_sel != 3'b000) begin
                    check_val({tag, "_s_addr"}, s_addr, exp_saddr);
                    check_val({tag, "_s_we"}, s_we, we);
                    check_val({tag, "_s_wdata"}, s_wdata, wdata);
                end
            end
            if (s_sel != 3'b000) begin
                nsel++;
                if (s_sel != exp_sel || s_addr != exp_saddr || s_wdata != wdata) unstable++;
            end
            if (bus_ready) begin
                got = 1'b1;
                lat = c;
                bus_req = 1'b0;
            end else begin
                // Master-side changes mid-access must not reach the slave.
                bus_addr  = 32'h2000_0000;
                bus_wdata = 32'h0;
            end
        end
        bus_req = 1'b0;
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_sel_cycles"}, nsel, (exp_sel != 3'b000) ? exp_lat - 1 : 0);
        check_val({tag, "_stable"}, unstable, 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int r1;
        int r2;
        reset_n = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = 32'h0; bus_wdata = 32'h0;
        wait_cfg = 0; extra_ready = 3'b000;
        repeat (3) @(negedge clk);
        check_val("rst_s_sel", s_sel, 3'b000);
        check_val("rst_s_we", s_we, 1'b0);
        check_val("rst_s_addr", s_addr, 32'h0);
        check_val("rst_s_wdata", s_wdata, 32'h0);
        check_val("rst_ready", bus_ready, 1'b0);
        check_val("rst_err", bus_err, 1'b0);
        check_val("rst_rdata", bus_rdata, 32'h0);
        check_val("rst_err_addr", err_addr, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        txn("rom_read", 32'h0000_0010, 1'b0, 32'h0, 0, 3'b001, 32'h10, 2, D0, 1'b0, 32'h0);
        txn("stk_write", 32'h1000_0004, 1'b1, 32'hCAFE_F00D, 3, 3'b010, 32'h4, 5, 32'h0, 1'b0, 32'h0);
        txn("unmapped", 32'h2000_0000, 1'b0, 32'h0, 0, 3'b000, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 32'h2000_0000);
        extra_ready = 3'b011;
        txn("timeout", 32'hF000_0008, 1'b0, 32'h0, 1000, 3'b100, 32'h8, 5, 32'hDEAD_BEEF, 1'b1, 32'hF000_0008);
        extra_ready = 3'b000;
        txn("rdy_on_to", 32'hF000_000C, 1'b0, 32'h0, 3, 3'b100, 32'hC, 5, D2, 1'b0, 32'hF000_0008);
        txn("rom_write", 32'h0000_0100, 1'b1, 32'h55, 1, 3'b001, 32'h100, 3, 32'h0, 1'b0, 32'hF000_0008);
        txn("overlap", 32'h0000_0020, 1'b0, 32'h0, 0, 3'b001, 32'h20, 2, D0, 1'b0, 32'hF000_0008);
        check_val("overlap_ovl_sel", ovl_sel_c1, 3'b001);

        // Back-to-back: bus_req held high across both responses.
        wait_cfg = 0;
        sb_q.push_back('{D0, 1'b0, 32'hF000_0008});
        sb_q.push_back('{D1, 1'b0, 32'hF000_0008});
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 32'h0000_0030;
        r1 = 0; r2 = 0;
        for (int c = 1; c <= 30 && r2 == 0; c++) begin
            @(negedge clk);
            if (c == 1) bus_addr = 32'h1000_0008;
            if (bus_ready) begin
                if (r1 == 0) r1 = c;
                else begin
                    r2 = c;
                    bus_req = 1'b0;
                end
            end
        end
        bus_req = 1'b0;
        check_val("b2b_first_lat", r1, 2);
        check_val("b2b_gap", r2 - r1, 3);
        repeat (2) @(negedge clk);

        // Reset while a slave is stalling: select drops at once, no response.
        wait_cfg = 1000;
        bus_req = 1'b1; bus_addr = 32'h1000_0000;
        repeat (2) @(negedge clk);
        check_val("rst_mid_pre_sel", s_sel, 3'b010);
        bus_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_sel", s_sel, 3'b000);
        check_val("rst_mid_err_addr", err_addr, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check_val("rst_mid_ready", bus_ready, 1'b0);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        txn("post_rst", 32'h0000_0044, 1'b0, 32'h0, 0, 3'b001, 32'h44, 2, D0, 1'b0, 32'h0);

        check_val("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
